reset_seq_gen: RTL and testbench

//   Upstream stimulus stage for the t_clk clock-domain test: sequences the reset_l

---
 rtl/reset_seq_gen.sv | 136 +++++++++++++
 tb/tb_reset_seq_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/reset_seq_gen.sv
// reset_seq_gen: drives the reset_l sequence for the t_clk clock-domain test.
// The sequence is held low, then high briefly, then a low pulse, then released.
// Also produces a divided clock-enable strobe and a saturating cycle counter
// so downstream checkers can be timed against it. All outputs are registered.
module reset_seq_gen #(
   parameter int unsigned HOLD_CYCLES  = 1,
   parameter int unsigned RUN1_CYCLES  = 1,
   parameter int unsigned PULSE_CYCLES = 9,
   parameter int unsigned DIV          = 2,
   parameter int unsigned CYC_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             reset_l,
   output logic             ce_out,
   output logic             done,
   output logic [1:0]       phase,
   output logic [CYC_W-1:0] cyc
);

   // The timer only needs to reach the longest phase length minus one
   localparam int unsigned TMAX01 = (HOLD_CYCLES > RUN1_CYCLES) ? HOLD_CYCLES : RUN1_CYCLES;
   localparam int unsigned TMAX   = (TMAX01 > PULSE_CYCLES) ? TMAX01 : PULSE_CYCLES;
   localparam int unsigned TW     = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int unsigned DW     = (DIV > 1) ? $clog2(DIV) : 1;

   localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] RUN1_LAST  = TW'(RUN1_CYCLES - 1);
   localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST   = DW'(DIV - 1);

   typedef enum logic [1:0] {
      StHold  = 2'd0,
      StRun1  = 2'd1,
      StPulse = 2'd2,
      StRun   = 2'd3
   } state_t;

   state_t         state;
   logic [TW-1:0]  timer;
   logic [DW-1:0]  div_cnt;
   logic           rl_fall;

   // phase is the state register itself, so it is registered by construction
   assign phase = state;

   // Flags the edges at which the FSM is about to drive reset_l low, so the
   // strobe can drop on the same edge instead of one cycle late
   always_comb begin
      rl_fall = 1'b0;
      if ((state == StRun1) && (timer == RUN1_LAST)) rl_fall = 1'b1;
      if ((state == StRun) && start)                 rl_fall = 1'b1;
   end

   // Sequencing FSM with registered reset_l and done
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= StHold;
         timer   <= '0;
         reset_l <= 1'b0;
         done    <= 1'b0;
      end else begin
         unique case (state)
            StHold: begin
               if (timer == HOLD_LAST) begin
                  state   <= StRun1;
                  timer   <= '0;
                  reset_l <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            StRun1: begin
               if (timer == RUN1_LAST) begin
                  state   <= StPulse;
                  timer   <= '0;
                  reset_l <= 1'b0;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            StPulse: begin
               if (timer == PULSE_LAST) begin
                  state   <= StRun;
                  timer   <= '0;
                  reset_l <= 1'b1;
                  done    <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            StRun: begin
               // A start here acts like a fresh reset release at this edge
               if (start) begin
                  state   <= StHold;
                  timer   <= '0;
                  reset_l <= 1'b0;
                  done    <= 1'b0;
               end
            end
            default: begin
               state   <= StHold;
               timer   <= '0;
               reset_l <= 1'b0;
               done    <= 1'b0;
            end
         endcase
      end
   end

   // Clock-enable divider, held cleared while reset_l is (or is becoming) low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         ce_out  <= 1'b0;
      end else if (!reset_l || rl_fall) begin
         div_cnt <= '0;
         ce_out  <= 1'b0;
      end else begin
         ce_out <= (div_cnt == DIV_LAST);
         if (div_cnt == DIV_LAST) div_cnt <= '0;
         else                     div_cnt <= div_cnt + 1'b1;
      end
   end

   // Free-running saturating cycle counter; start does not clear it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc <= '0;
      end else if (cyc != {CYC_W{1'b1}}) begin
         cyc <= cyc + 1'b1;
      end
   end

endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed bench for reset_seq_gen: default instance (H=1,S=1,L=9,DIV=2) and a
// second instance with H=3,S=2,L=4,DIV=1, sharing clock and reset.
module tb_reset_seq_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;

   logic        rl_a, ce_a, done_a;
   logic [1:0]  ph_a;
   logic [31:0] cyc_a;
   logic        rl_b, ce_b, done_b;
   logic [1:0]  ph_b;
   logic [31:0] cyc_b;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   reset_seq_gen u_dut_a (
      .clk     (clk),
      .reset   (reset),
      .start   (start_a),
      .reset_l (rl_a),
      .ce_out  (ce_a),
      .done    (done_a),
      .phase   (ph_a),
      .cyc     (cyc_a)
   );

   reset_seq_gen #(
      .HOLD_CYCLES  (3),
      .RUN1_CYCLES  (2),
      .PULSE_CYCLES (4),
      .DIV          (1),
      .CYC_W        (32)
   ) u_dut_b (
      .clk     (clk),
      .reset   (reset),
      .start   (start_b),
      .reset_l (rl_b),
      .ce_out  (ce_b),
      .done    (done_b),
      .phase   (ph_b),
      .cyc     (cyc_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected phase after posedge k for hold/run1/pulse lengths h/s/l
   function automatic int exp_ph(input int k, input int h, input int s, input int l);
      if (k < h)             return 0;
      else if (k < h + s)    return 1;
      else if (k < h + s + l) return 2;
      else                   return 3;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // kr: edge index relative to the last release/restart; kabs: since reset release
   task automatic chk_a(input int kr, input int kabs);
      int ph;
      ph = exp_ph(kr, 1, 1, 9);
      check($sformatf("a_phase k=%0d", kabs), 32'(ph_a), ph);
      check($sformatf("a_reset_l k=%0d", kabs), 32'(rl_a), ((ph == 1) || (ph == 3)) ? 1 : 0);
      check($sformatf("a_done k=%0d", kabs), 32'(done_a), (ph == 3) ? 1 : 0);
      check($sformatf("a_ce k=%0d", kabs), 32'(ce_a), ((kr >= 13) && (kr % 2 == 1)) ? 1 : 0);
      check($sformatf("a_cyc k=%0d", kabs), cyc_a, kabs);
   endtask

   task automatic chk_b(input int k);
      int ph;
      ph = exp_ph(k, 3, 2, 4);
      check($sformatf("b_phase k=%0d", k), 32'(ph_b), ph);
      check($sformatf("b_reset_l k=%0d", k), 32'(rl_b), ((ph == 1) || (ph == 3)) ? 1 : 0);
      check($sformatf("b_done k=%0d", k), 32'(done_b), (ph == 3) ? 1 : 0);
      check($sformatf("b_ce k=%0d", k), 32'(ce_b), ((k == 4) || (k >= 10)) ? 1 : 0);
      check($sformatf("b_cyc k=%0d", k), cyc_b, k);
   endtask

   task automatic chk_a_zero(input string tag);
      check({tag, "_reset_l"}, 32'(rl_a), 0);
      check({tag, "_ce"}, 32'(ce_a), 0);
      check({tag, "_done"}, 32'(done_a), 0);
      check({tag, "_phase"}, 32'(ph_a), 0);
      check({tag, "_cyc"}, cyc_a, 0);
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      // Reset takes effect before any clock edge
      #1 reset = 1'b1;
      #1;
      chk_a_zero("rst_a");
      check("rst_b_reset_l", 32'(rl_b), 0);
      check("rst_b_phase", 32'(ph_b), 0);
      repeat (2) @(posedge clk);
      release_reset();

      // Cases 1, 2, 6: default sequence and the short-parameter instance
      for (int k = 1; k <= 19; k++) begin
         step();
         chk_a(k, k);
         if (k <= 12) chk_b(k);
      end

      // Case 3: one-cycle start sampled at k=20 in RUN
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      chk_a(0, 20);
      for (int k = 21; k <= 33; k++) begin
         step();
         chk_a(k - 20, k);
      end
      check("b_done_unaffected", 32'(done_b), 1);

      // Case 5: start in non-RUN states is ignored
      reset = 1'b1;
      #1;
      chk_a_zero("rst2_a");
      release_reset();
      for (int k = 1; k <= 14; k++) begin
         start_a = ((k == 1) || (k == 4)) ? 1'b1 : 1'b0;
         step();
         start_a = 1'b0;
         chk_a(k, k);
         if (k <= 12) chk_b(k);
      end

      // Case 4: asynchronous reset mid-PULSE, then replay
      reset = 1'b1;
      #1;
      release_reset();
      for (int k = 1; k <= 5; k++) begin
         step();
         chk_a(k, k);
      end
      #3 reset = 1'b1;
      #1;
      chk_a_zero("async_a");
      release_reset();
      for (int k = 1; k <= 14; k++) begin
         step();
         chk_a(k, k);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
